cmp_tally: RTL and testbench

CMP_TALLY -- requirements
Module: cmp_tally

---
 rtl/cmp_tally.sv | 118 +++++++++++
 tb/tb_cmp_tally.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_tally.sv
// Tallies comparator LB/E/RB outcomes over a window of WINDOW accepted samples and registers a majority verdict.
// Optional feature: define CMP_TALLY_ERR_EN to count illegal (non-one-hot) samples on err_cnt.
module cmp_tally #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             lb,
  input  logic             e,
  input  logic             rb,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_lb,
  output logic [CNT_W-1:0] cnt_e,
  output logic [CNT_W-1:0] cnt_rb,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       result,
  output logic [1:0]       dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             legal;
  logic             last;
  logic [CNT_W-1:0] lb_next, e_next, rb_next;
  logic [1:0]       verdict;

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = COUNT;
      COUNT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_ready & in_valid;
  assign legal  = ({lb, e, rb} == 3'b100) | ({lb, e, rb} == 3'b010) | ({lb, e, rb} == 3'b001);
  assign last   = accept && (acc_cnt == CNT_W'(WINDOW - 1));

  // Post-update counts, so the verdict taken on the final edge includes the final sample.
  assign lb_next = cnt_lb + CNT_W'(accept & legal & lb);
  assign e_next  = cnt_e  + CNT_W'(accept & legal & e);
  assign rb_next = cnt_rb + CNT_W'(accept & legal & rb);

  always_comb begin
    verdict = 2'b00;
    if ((lb_next > e_next) && (lb_next > rb_next))      verdict = 2'b01;
    else if ((rb_next > lb_next) && (rb_next > e_next)) verdict = 2'b10;
    else if ((e_next > lb_next) && (e_next > rb_next))  verdict = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lb  <= '0;
      cnt_e   <= '0;
      cnt_rb  <= '0;
      acc_cnt <= '0;
      result  <= 2'b00;
    end else if ((state == IDLE) && start) begin
      cnt_lb  <= '0;
      cnt_e   <= '0;
      cnt_rb  <= '0;
      acc_cnt <= '0;
      result  <= 2'b00;
    end else if (accept) begin
      cnt_lb  <= lb_next;
      cnt_e   <= e_next;
      cnt_rb  <= rb_next;
      acc_cnt <= acc_cnt + CNT_W'(1);
      if (last) result <= verdict;
    end
  end

`ifdef CMP_TALLY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_cnt <= '0;
    else if ((state == IDLE) && start) err_cnt <= '0;
    else if (accept && !legal)         err_cnt <= err_cnt + CNT_W'(1);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_tally.sv
// Bench for cmp_tally: table of full windows plus sequences for gaps, ignored start, start-edge sample and mid-window reset.
module tb_cmp_tally;
  localparam int WINDOW = 8;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, lb, e, rb;
  logic             in_ready, busy, done;
  logic [CNT_W-1:0] cnt_lb, cnt_e, cnt_rb, err_cnt;
  logic [1:0]       result, dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  cmp_tally #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .lb(lb), .e(e), .rb(rb), .in_ready(in_ready), .busy(busy), .done(done),
    .cnt_lb(cnt_lb), .cnt_e(cnt_e), .cnt_rb(cnt_rb), .err_cnt(err_cnt),
    .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] samples;   // sample 0 in the top three bits, each as {lb,e,rb}
    logic [3:0]  exp_lb;
    logic [3:0]  exp_e;
    logic [3:0]  exp_rb;
    logic [3:0]  exp_err;   // illegal samples, visible only with the error counter enabled
    logic [1:0]  exp_res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_err_of(input vec_t v);
`ifdef CMP_TALLY_ERR_EN
    return v.exp_err;
`else
    return 4'd0;
`endif
  endfunction

  // Runs one full window; starts and finishes on a falling edge.
  task automatic run_window(input vec_t v, input bit gaps, input bit valid_on_start);
    logic [2:0] s;
    logic [1:0] exp_res;
    exp_q.push_back(v.exp_res);
    @(negedge clk);
    start    = 1'b1;
    in_valid = valid_on_start;
    {lb, e, rb} = valid_on_start ? 3'b100 : 3'b000;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("start_ready", in_ready, 1);
    check("start_clear_lb", cnt_lb, 0);
    check("start_clear_result", result, 0);
    for (int i = 0; i < WINDOW; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        start    = 1'b1;
        {lb, e, rb} = 3'b100;
        @(negedge clk);
        start = 1'b0;
        check("gap_busy", busy, 1);
        check("gap_no_done", done, 0);
      end
      s = v.samples[23-3*i -: 3];
      in_valid = 1'b1;
      {lb, e, rb} = s;
      @(posedge clk);
      #1;
      check("done_timing", done, (i == WINDOW - 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    {lb, e, rb} = 3'b000;
    start = 1'b1;
    exp_res = exp_q.pop_front();
    check("done_busy", busy, 1);
    check("done_ready", in_ready, 0);
    check("cnt_lb", cnt_lb, v.exp_lb);
    check("cnt_e", cnt_e, v.exp_e);
    check("cnt_rb", cnt_rb, v.exp_rb);
    check("err_cnt", err_cnt, exp_err_of(v));
    check("result", result, exp_res);
    @(posedge clk);
    #1;
    check("idle_state", dbg_state, 0);
    check("idle_done_low", done, 0);
    check("idle_busy_low", busy, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hold_state", dbg_state, 0);
    check("hold_cnt_lb", cnt_lb, v.exp_lb);
    check("hold_cnt_e", cnt_e, v.exp_e);
    check("hold_cnt_rb", cnt_rb, v.exp_rb);
    check("hold_result", result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; lb = 1'b0; e = 1'b0; rb = 1'b0;

    vecs[0] = '{ {8{3'b100}}, 4'd8, 4'd0, 4'd0, 4'd0, 2'b01 };
    vecs[1] = '{ {3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b100},
                 4'd3, 4'd3, 4'd2, 4'd0, 2'b00 };
    vecs[2] = '{ {3'b110, 3'b110, 3'b110, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001},
                 4'd0, 4'd0, 4'd5, 4'd3, 2'b10 };
    vecs[3] = '{ {8{3'b010}}, 4'd0, 4'd8, 4'd0, 4'd0, 2'b11 };
    vecs[4] = '{ {8{3'b000}}, 4'd0, 4'd0, 4'd0, 4'd8, 2'b00 };
    vecs[5] = '{ {3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010, 3'b010, 3'b111},
                 4'd2, 4'd2, 4'd3, 4'd1, 2'b10 };
    vecs[6] = '{ {3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001},
                 4'd4, 4'd0, 4'd4, 4'd0, 2'b00 };
    vecs[7] = '{ {3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b101, 3'b100},
                 4'd2, 4'd5, 4'd0, 4'd1, 2'b11 };

    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cnt_lb", cnt_lb, 0);
    check("rst_cnt_e", cnt_e, 0);
    check("rst_cnt_rb", cnt_rb, 0);
    check("rst_err", err_cnt, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_window(vecs[v], 1'b0, 1'b0);

    // Valid toggled every other cycle with start pulses inside the window.
    run_window(vecs[1], 1'b1, 1'b0);

    // Sample presented on the start edge must not be counted.
    run_window('{ {8{3'b001}}, 4'd0, 4'd0, 4'd8, 4'd0, 2'b10 }, 1'b0, 1'b1);

    // Asynchronous reset after five accepts discards the partial tally.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      {lb, e, rb} = 3'b100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    {lb, e, rb} = 3'b000;
    check("pre_rst_cnt_lb", cnt_lb, 5);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt_lb", cnt_lb, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", in_ready, 0);
    check("async_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(vecs[3], 1'b0, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
